ecc_sram_scrub: RTL and testbench

- Parametrised successor to the fixed 32-bit SECDED SRAM with error injection.
- Stores DATA_W-bit words as Hamming SECDED codewords in a DEPTH-entry simple dual-port array.
- Supports per-write error injection, a registered correcting read path, a post-reset zero-init sweep, and a background scrubber that rewrites single-bit-corrected words.
- Sits between the datapath and on-chip RAM, and exports error statistics to the status registers.

---
 rtl/ecc_sram_scrub.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_ecc_sram_scrub.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_sram_scrub.sv
// SECDED-protected simple dual-port SRAM with write-side error injection,
// post-reset zero-fill, a 2-stage correcting read pipeline and a background scrubber.
module ecc_sram_scrub #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16,
    localparam int DEPTH = 2 ** ADDR_W,
    // Smallest r with 2**r >= DATA_W+r+1; r is either clog2(DATA_W+1) or one more.
    localparam int CHK_W = $clog2(DATA_W + 1 + $clog2(DATA_W + 1)),
    localparam int PAR_W = CHK_W + 1,
    localparam int CW_W  = DATA_W + PAR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [CW_W-1:0]   inj_mask,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_valid,
    output logic [DATA_W-1:0] r_data,
    output logic [PAR_W-1:0]  r_syn,
    output logic              r_sgl,
    output logic              r_dbl,
    input  logic              scrub_en,
    output logic [ADDR_W-1:0] scrub_addr,
    output logic              init_done,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  sgl_cnt,
    output logic [CNT_W-1:0]  dbl_cnt
);

    function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] cw;
        logic            par;
        int              di;
        cw = '0;
        di = 0;
        for (int j = 1; j < CW_W; j++) begin
            if ((j & (j - 1)) != 0) begin
                cw[j] = d[di];
                di++;
            end
        end
        for (int k = 0; k < CHK_W; k++) begin
            par = 1'b0;
            for (int j = 1; j < CW_W; j++) begin
                if (((j >> k) & 1) != 0) par = par ^ cw[j];
            end
            cw[1 << k] = par;
        end
        cw[0] = ^cw[CW_W-1:1];
        return cw;
    endfunction

    function automatic logic [PAR_W-1:0] syndrome(input logic [CW_W-1:0] cw);
        logic [CHK_W-1:0] h;
        h = '0;
        for (int j = 1; j < CW_W; j++) begin
            if (cw[j]) h = h ^ CHK_W'(j);
        end
        return {^cw, h};
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] d;
        int                di;
        d  = '0;
        di = 0;
        for (int j = 1; j < CW_W; j++) begin
            if ((j & (j - 1)) != 0) begin
                d[di] = cw[j];
                di++;
            end
        end
        return d;
    endfunction

    typedef enum logic {INIT, RUN} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] init_ptr_reg, init_ptr_next;
    logic              init_done_reg;

    logic [CW_W-1:0]   mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [CW_W-1:0]   mem_wdata;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;

    logic              run, user_wr, scrub_issue, wb_exec, wb_new;
    logic [ADDR_W-1:0] scrub_addr_reg;

    logic [CW_W-1:0]   a_cw_reg;
    logic              a_usr_reg, a_scr_reg;
    logic [ADDR_W-1:0] a_addr_reg;
    logic [CW_W-1:0]   b_cw_reg;
    logic [PAR_W-1:0]  b_syn_reg;
    logic              b_usr_reg, b_scr_reg, b_kill_reg;
    logic [ADDR_W-1:0] b_addr_reg;

    logic [CHK_W-1:0]  dec_h;
    logic              dec_p, dec_in_range, dec_sgl, dec_dbl;
    logic [CW_W-1:0]   flip, fix_cw;
    logic [DATA_W-1:0] dec_data;

    logic              r_valid_reg, r_sgl_reg, r_dbl_reg;
    logic [DATA_W-1:0] r_data_reg;
    logic [PAR_W-1:0]  r_syn_reg;
    logic [1:0]        hit_reg;
    logic [CNT_W-1:0]  cnt_reg [2];

    logic              wb_pend_reg, wb_pend_next;
    logic [ADDR_W-1:0] wb_addr_reg, wb_addr_next;
    logic [CW_W-1:0]   wb_cw_reg, wb_cw_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= INIT;
            init_ptr_reg  <= '0;
            init_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            init_ptr_reg  <= init_ptr_next;
            init_done_reg <= (state_reg == RUN);
        end
    end

    always_comb begin
        state_next    = state_reg;
        init_ptr_next = init_ptr_reg;
        case (state_reg)
            INIT: begin
                init_ptr_next = init_ptr_reg + 1'b1;
                if (init_ptr_reg == '1) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    assign run         = (state_reg == RUN);
    assign user_wr     = run & w_en;
    assign scrub_issue = run & scrub_en & ~r_en & ~w_en & ~wb_pend_reg;
    assign wb_exec     = run & wb_pend_reg & ~w_en;
    assign rd_en       = (run & r_en) | scrub_issue;
    assign rd_addr     = r_en ? r_addr : scrub_addr_reg;

    // The codeword of all-zero data is all zeros, so the init sweep writes '0.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (!run) begin
            mem_we    = 1'b1;
            mem_waddr = init_ptr_reg;
        end else if (w_en) begin
            mem_we    = 1'b1;
            mem_waddr = w_addr;
            mem_wdata = encode(w_data) ^ inj_mask;
        end else if (wb_pend_reg) begin
            mem_we    = 1'b1;
            mem_waddr = wb_addr_reg;
            mem_wdata = wb_cw_reg;
        end
    end

    // Read-before-write: a read racing a write to the same address sees old data.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (rd_en) a_cw_reg <= mem[rd_addr];
    end

    assign dec_h        = b_syn_reg[CHK_W-1:0];
    assign dec_p        = b_syn_reg[CHK_W];
    assign dec_in_range = ({1'b0, dec_h} < PAR_W'(CW_W));
    assign dec_sgl      = dec_p & dec_in_range;
    assign dec_dbl      = (~dec_p & (dec_h != '0)) | (dec_p & ~dec_in_range);

    always_comb begin
        flip = '0;
        for (int j = 0; j < CW_W; j++) begin
            flip[j] = dec_sgl & (dec_h == CHK_W'(j));
        end
    end

    assign fix_cw   = b_cw_reg ^ flip;
    assign dec_data = extract(fix_cw);
    // A user write to the word between its scrub read and now makes the correction stale.
    assign wb_new   = b_scr_reg & dec_sgl & ~b_kill_reg & ~(user_wr & (w_addr == b_addr_reg));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_usr_reg      <= 1'b0;
            a_scr_reg      <= 1'b0;
            a_addr_reg     <= '0;
            b_cw_reg       <= '0;
            b_syn_reg      <= '0;
            b_usr_reg      <= 1'b0;
            b_scr_reg      <= 1'b0;
            b_kill_reg     <= 1'b0;
            b_addr_reg     <= '0;
            r_valid_reg    <= 1'b0;
            r_sgl_reg      <= 1'b0;
            r_dbl_reg      <= 1'b0;
            r_data_reg     <= '0;
            r_syn_reg      <= '0;
            hit_reg        <= '0;
            scrub_addr_reg <= '0;
        end else begin
            a_usr_reg  <= run & r_en;
            a_scr_reg  <= scrub_issue;
            a_addr_reg <= rd_addr;
            b_cw_reg   <= a_cw_reg;
            b_syn_reg  <= syndrome(a_cw_reg);
            b_usr_reg  <= a_usr_reg;
            b_scr_reg  <= a_scr_reg;
            b_kill_reg <= user_wr & (w_addr == a_addr_reg);
            b_addr_reg <= a_addr_reg;
            r_valid_reg <= b_usr_reg;
            if (b_usr_reg) begin
                r_sgl_reg  <= dec_sgl;
                r_dbl_reg  <= dec_dbl;
                r_data_reg <= dec_data;
                r_syn_reg  <= b_syn_reg;
            end
            hit_reg <= {2{b_usr_reg | b_scr_reg}} & {dec_dbl, dec_sgl};
            if (scrub_issue) scrub_addr_reg <= scrub_addr_reg + 1'b1;
        end
    end

    // A second correction arriving while one is still queued is dropped; the next pass catches it.
    always_comb begin
        wb_pend_next = wb_pend_reg;
        wb_addr_next = wb_addr_reg;
        wb_cw_next   = wb_cw_reg;
        if (wb_pend_reg && (wb_exec || (user_wr && (w_addr == wb_addr_reg)))) wb_pend_next = 1'b0;
        if (wb_new && !wb_pend_next) begin
            wb_pend_next = 1'b1;
            wb_addr_next = b_addr_reg;
            wb_cw_next   = fix_cw;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_pend_reg <= 1'b0;
            wb_addr_reg <= '0;
            wb_cw_reg   <= '0;
        end else begin
            wb_pend_reg <= wb_pend_next;
            wb_addr_reg <= wb_addr_next;
            wb_cw_reg   <= wb_cw_next;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_reg[gi] <= '0;
            end else if (clr_cnt) begin
                cnt_reg[gi] <= '0;
            end else if (hit_reg[gi] && (cnt_reg[gi] != '1)) begin
                cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end
        end
    end

    assign r_valid    = r_valid_reg;
    assign r_data     = r_data_reg;
    assign r_syn      = r_syn_reg;
    assign r_sgl      = r_sgl_reg;
    assign r_dbl      = r_dbl_reg;
    assign scrub_addr = scrub_addr_reg;
    assign init_done  = init_done_reg;
    assign sgl_cnt    = cnt_reg[0];
    assign dbl_cnt    = cnt_reg[1];

endmodule

// File: tb/tb_ecc_sram_scrub.sv
// Directed bench for ecc_sram_scrub (DATA_W=32, ADDR_W=4): init sweep, decode cases,
// scrubber writeback, read/write ordering, mid-run reset and counter clear.
module tb_ecc_sram_scrub;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 16;
    localparam int PAR_W  = 7;
    localparam int CW_W   = 39;

    logic              clk;
    logic              rst;
    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [CW_W-1:0]   inj_mask;
    logic              r_en;
    logic [ADDR_W-1:0] r_addr;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [PAR_W-1:0]  r_syn;
    logic              r_sgl;
    logic              r_dbl;
    logic              scrub_en;
    logic [ADDR_W-1:0] scrub_addr;
    logic              init_done;
    logic              clr_cnt;
    logic [CNT_W-1:0]  sgl_cnt;
    logic [CNT_W-1:0]  dbl_cnt;

    int checks;
    int failures;

    ecc_sram_scrub #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .inj_mask(inj_mask),
        .r_en(r_en), .r_addr(r_addr),
        .r_valid(r_valid), .r_data(r_data), .r_syn(r_syn), .r_sgl(r_sgl), .r_dbl(r_dbl),
        .scrub_en(scrub_en), .scrub_addr(scrub_addr), .init_done(init_done),
        .clr_cnt(clr_cnt), .sgl_cnt(sgl_cnt), .dbl_cnt(dbl_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [CW_W-1:0] m);
        @(negedge clk);
        w_en = 1'b1; w_addr = a; w_data = d; inj_mask = m;
        @(negedge clk);
        w_en = 1'b0; inj_mask = '0;
        $display("write addr=%0d data=%0d mask=%0h", a, d, m);
    endtask

    // Returns r_valid one and two edges after the sampling edge, plus the outputs at two.
    task automatic do_read(input logic [ADDR_W-1:0] a, output logic v1, output logic v2,
                           output logic [DATA_W-1:0] d, output logic [PAR_W-1:0] s,
                           output logic sg, output logic db);
        @(negedge clk);
        r_en = 1'b1; r_addr = a;
        @(negedge clk);
        r_en = 1'b0;
        @(negedge clk);
        v1 = r_valid;
        @(negedge clk);
        v2 = r_valid; d = r_data; s = r_syn; sg = r_sgl; db = r_dbl;
        $display("read  addr=%0d valid=%0b data=%0d syn=%0h sgl=%0b dbl=%0b", a, v2, d, s, sg, db);
    endtask

    task automatic wait_init(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!init_done && n < 40);
    endtask

    task automatic test_reset;
        int n;
        logic v1, v2, sg, db;
        logic [DATA_W-1:0] d;
        logic [PAR_W-1:0] s;
        repeat (3) @(negedge clk);
        checks++;
        if ({r_valid, r_sgl, r_dbl, r_data, r_syn, scrub_addr, init_done, sgl_cnt, dbl_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%0b data=%0h syn=%0h scrub=%0d done=%0b cnt=%0d/%0d expected all 0",
                     r_valid, r_data, r_syn, scrub_addr, init_done, sgl_cnt, dbl_cnt);
        end
        rst = 1'b0;
        wait_init(n);
        checks++;
        if (n !== 17) begin
            failures++;
            $display("FAIL init_latency: got %0d cycles expected 17", n);
        end
        do_read(4'd7, v1, v2, d, s, sg, db);
        checks++;
        if ({v2, d, s, sg, db} !== {1'b1, 32'd0, 7'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL init_read: got valid=%0b data=%0h syn=%0h sgl=%0b dbl=%0b expected 1/0/0/0/0", v2, d, s, sg, db);
        end
    endtask

    task automatic test_clean;
        logic v1, v2, sg, db;
        logic [DATA_W-1:0] d;
        logic [PAR_W-1:0] s;
        do_write(4'd1, 32'd10, '0);
        do_read(4'd1, v1, v2, d, s, sg, db);
        checks++;
        if ({v1, v2} !== 2'b01) begin
            failures++;
            $display("FAIL clean_latency: got valid N+1=%0b N+2=%0b expected 0 1", v1, v2);
        end
        checks++;
        if ({d, s, sg, db} !== {32'd10, 7'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL clean_data: got data=%0d syn=%0h sgl=%0b dbl=%0b expected 10/0/0/0", d, s, sg, db);
        end
        @(negedge clk);
        checks++;
        if ({r_valid, r_data} !== {1'b0, 32'd10}) begin
            failures++;
            $display("FAIL clean_hold: got valid=%0b data=%0d expected 0 10", r_valid, r_data);
        end
    endtask

    task automatic test_single;
        logic v1, v2, sg, db;
        logic [DATA_W-1:0] d;
        logic [PAR_W-1:0] s;
        do_write(4'd2, 32'd20, 39'h8);
        do_read(4'd2, v1, v2, d, s, sg, db);
        checks++;
        if ({v2, d, s, sg, db} !== {1'b1, 32'd20, 7'h43, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL single_decode: got valid=%0b data=%0d syn=%0h sgl=%0b dbl=%0b expected 1/20/43/1/0", v2, d, s, sg, db);
        end
        @(negedge clk);
        checks++;
        if (sgl_cnt !== 16'd1) begin
            failures++;
            $display("FAIL single_count: got %0d expected 1", sgl_cnt);
        end
    endtask

    task automatic test_double;
        logic v1, v2, sg, db;
        logic [DATA_W-1:0] d;
        logic [PAR_W-1:0] s;
        do_write(4'd3, 32'd30, 39'h220);
        do_read(4'd3, v1, v2, d, s, sg, db);
        checks++;
        if ({v2, d, s, sg, db} !== {1'b1, 32'd12, 7'h0C, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL double_decode: got valid=%0b data=%0d syn=%0h sgl=%0b dbl=%0b expected 1/12/0c/0/1", v2, d, s, sg, db);
        end
        @(negedge clk);
        checks++;
        if ({sgl_cnt, dbl_cnt} !== {16'd1, 16'd1}) begin
            failures++;
            $display("FAIL double_count: got sgl=%0d dbl=%0d expected 1 1", sgl_cnt, dbl_cnt);
        end
        do_write(4'd2, 32'd20, '0);
        do_read(4'd2, v1, v2, d, s, sg, db);
        checks++;
        if ({v2, d, s, sg, db} !== {1'b1, 32'd20, 7'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL rewrite_clean: got valid=%0b data=%0d syn=%0h sgl=%0b dbl=%0b expected 1/20/0/0/0", v2, d, s, sg, db);
        end
    endtask

    task automatic test_scrub;
        logic v1, v2, sg, db;
        logic [DATA_W-1:0] d;
        logic [PAR_W-1:0] s;
        do_write(4'd5, 32'd40, 39'h1);
        scrub_en = 1'b1;
        repeat (20) @(negedge clk);
        scrub_en = 1'b0;
        // 16 issues + 1 stall for the addr5 writeback + 3 more issues (0,1,2)
        checks++;
        if (scrub_addr !== 4'd3) begin
            failures++;
            $display("FAIL scrub_wrap: got scrub_addr=%0d expected 3", scrub_addr);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({sgl_cnt, dbl_cnt} !== {16'd2, 16'd2}) begin
            failures++;
            $display("FAIL scrub_count: got sgl=%0d dbl=%0d expected 2 2", sgl_cnt, dbl_cnt);
        end
        do_read(4'd5, v1, v2, d, s, sg, db);
        checks++;
        if ({v2, d, s, sg, db} !== {1'b1, 32'd40, 7'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL scrub_writeback: got valid=%0b data=%0d syn=%0h sgl=%0b dbl=%0b expected 1/40/0/0/0", v2, d, s, sg, db);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        w_en = 1'b1; w_addr = 4'd1; w_data = 32'd77; inj_mask = '0;
        r_en = 1'b1; r_addr = 4'd1;
        @(negedge clk);
        w_en = 1'b0;
        @(negedge clk);
        r_en = 1'b0;
        checks++;
        if (r_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_early: got valid=%0b expected 0", r_valid);
        end
        @(negedge clk);
        $display("read  addr=1 valid=%0b data=%0d (same-cycle write)", r_valid, r_data);
        checks++;
        if ({r_valid, r_data} !== {1'b1, 32'd10}) begin
            failures++;
            $display("FAIL b2b_old_data: got valid=%0b data=%0d expected 1 10", r_valid, r_data);
        end
        @(negedge clk);
        $display("read  addr=1 valid=%0b data=%0d", r_valid, r_data);
        checks++;
        if ({r_valid, r_data} !== {1'b1, 32'd77}) begin
            failures++;
            $display("FAIL b2b_new_data: got valid=%0b data=%0d expected 1 77", r_valid, r_data);
        end
        @(negedge clk);
        checks++;
        if (r_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_pulse: got valid=%0b expected 0", r_valid);
        end
    endtask

    task automatic test_reset_mid_run;
        int n;
        logic v1, v2, sg, db;
        logic [DATA_W-1:0] d;
        logic [PAR_W-1:0] s;
        do_write(4'd4, 32'd55, '0);
        do_read(4'd4, v1, v2, d, s, sg, db);
        checks++;
        if (d !== 32'd55) begin
            failures++;
            $display("FAIL pre_reset_read: got %0d expected 55", d);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({r_valid, r_sgl, r_dbl, r_data, r_syn, scrub_addr, init_done, sgl_cnt, dbl_cnt} !== '0) begin
            failures++;
            $display("FAIL midrun_reset: got data=%0h syn=%0h scrub=%0d done=%0b cnt=%0d/%0d expected all 0",
                     r_data, r_syn, scrub_addr, init_done, sgl_cnt, dbl_cnt);
        end
        rst = 1'b0;
        wait_init(n);
        checks++;
        if (n !== 17) begin
            failures++;
            $display("FAIL reinit_latency: got %0d cycles expected 17", n);
        end
        do_read(4'd4, v1, v2, d, s, sg, db);
        checks++;
        if ({v2, d, s} !== {1'b1, 32'd0, 7'd0}) begin
            failures++;
            $display("FAIL reinit_read: got valid=%0b data=%0d syn=%0h expected 1/0/0", v2, d, s);
        end
        do_write(4'd6, 32'd5, 39'h8);
        do_read(4'd6, v1, v2, d, s, sg, db);
        @(negedge clk);
        checks++;
        if ({sg, sgl_cnt} !== {1'b1, 16'd1}) begin
            failures++;
            $display("FAIL clr_setup: got sgl=%0b sgl_cnt=%0d expected 1 1", sg, sgl_cnt);
        end
        do_read(4'd6, v1, v2, d, s, sg, db);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        checks++;
        if ({sg, sgl_cnt, dbl_cnt} !== {1'b1, 16'd0, 16'd0}) begin
            failures++;
            $display("FAIL clr_priority: got sgl=%0b sgl_cnt=%0d dbl_cnt=%0d expected 1 0 0", sg, sgl_cnt, dbl_cnt);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        w_en     = 1'b0;
        w_addr   = '0;
        w_data   = '0;
        inj_mask = '0;
        r_en     = 1'b0;
        r_addr   = '0;
        scrub_en = 1'b0;
        clr_cnt  = 1'b0;
        test_reset();
        test_clean();
        test_single();
        test_double();
        test_scrub();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
